// File: rtl/alu_src_b_pkg.sv
// Shared definitions for the ALU operand-B source stage:
// occupancy state encoding and operand mode offsets.
package alu_src_b_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam int OFS_CONST    = 0;
   localparam int OFS_IMM      = 1;
   localparam int OFS_IMM_SHL2 = 2;

endpackage

// File: rtl/alu_src_b_if.sv
// Valid/ready bundle for the operand-B stage:
// upstream transfer on the in side, ALU-facing operand on the out side.
interface alu_src_b_if #(
   parameter int WIDTH    = 32,
   parameter int NUM_DATA = 3
);
   localparam int SEL_W = $clog2(NUM_DATA + 3);

   logic                      in_valid;
   logic                      in_ready;
   logic [SEL_W-1:0]          sel;
   logic [NUM_DATA*WIDTH-1:0] data_in;
   logic [15:0]               imm16;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          data_out;
   logic                      sel_err;

   modport master (
      output in_valid, sel, data_in, imm16, out_ready,
      input  in_ready, out_valid, data_out, sel_err
   );

   modport slave (
      input  in_valid, sel, data_in, imm16, out_ready,
      output in_ready, out_valid, data_out, sel_err
   );

endinterface

// File: rtl/alu_src_b_select.sv
// Combinational operand-B mux: register channels, PC increment
// constant, sign-extended immediate and immediate shifted left by 2.
module alu_src_b_select
   import alu_src_b_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_DATA  = 3,
   parameter int CONST_VAL = 4,
   localparam int SEL_W    = $clog2(NUM_DATA + 3)
) (
   input  logic [SEL_W-1:0]          i_sel,
   input  logic [NUM_DATA*WIDTH-1:0] i_data_in,
   input  logic [15:0]               i_imm16,
   output logic [WIDTH-1:0]          o_operand,
   output logic                      o_err
);

   logic [WIDTH-1:0] w_chan;
   logic [WIDTH-1:0] w_imm_sx;
   logic             w_is_data;
   logic             w_is_const;
   logic             w_is_imm;
   logic             w_is_shl;

   assign w_imm_sx   = {{(WIDTH-16){i_imm16[15]}}, i_imm16};
   assign w_is_data  = int'(i_sel) < NUM_DATA;
   assign w_is_const = int'(i_sel) == NUM_DATA + OFS_CONST;
   assign w_is_imm   = int'(i_sel) == NUM_DATA + OFS_IMM;
   assign w_is_shl   = int'(i_sel) == NUM_DATA + OFS_IMM_SHL2;

   // Pick the register channel addressed by sel.
   always_comb begin
      w_chan = '0;
      for (int k = 0; k < NUM_DATA; k++) begin
         if (i_sel == SEL_W'(k)) begin
            w_chan = i_data_in[k*WIDTH +: WIDTH];
         end
      end
   end

   // Decode mode; anything above the shifted immediate is an error.
   always_comb begin
      o_operand = '0;
      o_err     = 1'b0;
      unique case (1'b1)
         w_is_data:  o_operand = w_chan;
         w_is_const: o_operand = WIDTH'(CONST_VAL);
         w_is_imm:   o_operand = w_imm_sx;
         w_is_shl:   o_operand = w_imm_sx << 2;
         default:    o_err     = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_src_b_stage.sv
// Operand-B pipeline stage: registered mux output behind a
// main + skid buffer so in_ready can come straight from a flop.
module alu_src_b_stage
   import alu_src_b_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_DATA  = 3,
   parameter int CONST_VAL = 4,
   localparam int SEL_W    = $clog2(NUM_DATA + 3)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   alu_src_b_if.slave bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_main_data;
   logic             r_main_err;
   logic [WIDTH-1:0] r_skid_data;
   logic             r_skid_err;

   logic [WIDTH-1:0] w_operand;
   logic             w_err;
   logic             w_in;
   logic             w_out;
   logic             w_load_main;
   logic             w_load_skid;
   logic             w_shift;

   alu_src_b_select #(
      .WIDTH     (WIDTH),
      .NUM_DATA  (NUM_DATA),
      .CONST_VAL (CONST_VAL)
   ) u_select (
      .i_sel     (bus.sel),
      .i_data_in (bus.data_in),
      .i_imm16   (bus.imm16),
      .o_operand (w_operand),
      .o_err     (w_err)
   );

   assign w_in  = bus.in_valid & r_in_ready;
   assign w_out = r_out_valid & bus.out_ready;

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.data_out  = r_main_data;
   assign bus.sel_err   = r_main_err;

   // Occupancy register; ready/valid flags registered from next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != ST_TWO);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
      end
   end

   // Next occupancy from the in/out transfers; flush empties the stage.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_in) w_state_nxt = ST_ONE;
         ST_ONE: begin
            if (w_in && !w_out)      w_state_nxt = ST_TWO;
            else if (!w_in && w_out) w_state_nxt = ST_EMPTY;
         end
         ST_TWO: if (w_out) w_state_nxt = ST_ONE;
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (flush) w_state_nxt = ST_EMPTY;
   end

   // Datapath load enables derived from state and transfers.
   always_comb begin
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_shift     = 1'b0;
      if (!flush) begin
         unique case (r_state)
            ST_EMPTY: w_load_main = w_in;
            ST_ONE: begin
               w_load_main = w_in & w_out;
               w_load_skid = w_in & ~w_out;
            end
            ST_TWO: w_shift = w_out;
            default: ;
         endcase
      end
   end

   // Main and skid operand registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_main_data <= '0;
         r_main_err  <= 1'b0;
         r_skid_data <= '0;
         r_skid_err  <= 1'b0;
      end else begin
         if (w_load_main) begin
            r_main_data <= w_operand;
            r_main_err  <= w_err;
         end else if (w_shift) begin
            r_main_data <= r_skid_data;
            r_main_err  <= r_skid_err;
         end
         if (w_load_skid) begin
            r_skid_data <= w_operand;
            r_skid_err  <= w_err;
         end
      end
   end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Directed vectors plus backpressure/flush/reset sequences and a
// random valid/ready scoreboard run for alu_src_b_stage.
module tb_alu_src_b_stage;

   localparam int W  = 32;
   localparam int ND = 3;

   typedef struct {
      logic [2:0]      sel;
      logic [15:0]     imm;
      logic [ND*W-1:0] data;
      logic [W-1:0]    exp;
      logic            exp_err;
   } vec_t;

   typedef struct {
      logic         err;
      logic [W-1:0] data;
   } exp_t;

   logic clk;
   logic reset;
   logic flush;
   int   n_pass;
   int   n_total;

   alu_src_b_if #(.WIDTH(W), .NUM_DATA(ND)) bus ();

   alu_src_b_stage #(
      .WIDTH     (W),
      .NUM_DATA  (ND),
      .CONST_VAL (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   function automatic exp_t model(input logic [2:0] sel,
                                  input logic [ND*W-1:0] d,
                                  input logic [15:0] imm);
      exp_t r;
      logic [W-1:0] sx;
      sx = {{16{imm[15]}}, imm};
      r.err = 1'b0;
      r.data = '0;
      case (sel)
         3'd0: r.data = d[31:0];
         3'd1: r.data = d[63:32];
         3'd2: r.data = d[95:64];
         3'd3: r.data = 32'd4;
         3'd4: r.data = sx;
         3'd5: r.data = {sx[29:0], 2'b00};
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   vec_t vecs[12];
   exp_t q[$];

   initial begin
      logic [ND*W-1:0] chans;
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      flush   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.sel       = '0;
      bus.data_in   = '0;
      bus.imm16     = '0;

      chans = {32'h3333_CCCC, 32'h2222_BBBB, 32'h1111_AAAA};
      vecs[0]  = '{3'd3, 16'h0000, chans, 32'h0000_0004, 1'b0};
      vecs[1]  = '{3'd0, 16'h0000, chans, 32'h1111_AAAA, 1'b0};
      vecs[2]  = '{3'd1, 16'h0000, chans, 32'h2222_BBBB, 1'b0};
      vecs[3]  = '{3'd2, 16'h0000, chans, 32'h3333_CCCC, 1'b0};
      vecs[4]  = '{3'd4, 16'hFFFC, chans, 32'hFFFF_FFFC, 1'b0};
      vecs[5]  = '{3'd5, 16'hFFFC, chans, 32'hFFFF_FFF0, 1'b0};
      vecs[6]  = '{3'd5, 16'h7FFF, chans, 32'h0001_FFFC, 1'b0};
      vecs[7]  = '{3'd4, 16'h7FFF, chans, 32'h0000_7FFF, 1'b0};
      vecs[8]  = '{3'd5, 16'h8000, chans, 32'hFFFE_0000, 1'b0};
      vecs[9]  = '{3'd6, 16'h1234, chans, 32'h0000_0000, 1'b1};
      vecs[10] = '{3'd7, 16'h1234, chans, 32'h0000_0000, 1'b1};
      vecs[11] = '{3'd3, 16'hFFFF, '0,    32'h0000_0004, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_data_out",  bus.data_out,       32'd0);
      chk("rst_sel_err",   32'(bus.sel_err),   32'd0);

      // Single transfers from an empty stage.
      for (int i = 0; i < 12; i++) begin
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b1;
         bus.sel       = vecs[i].sel;
         bus.data_in   = vecs[i].data;
         bus.imm16     = vecs[i].imm;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("vec%0d_data", i),  bus.data_out, vecs[i].exp);
         chk($sformatf("vec%0d_err", i),   32'(bus.sel_err),
             32'(vecs[i].exp_err));
         bus.in_valid = 1'b0;
         tick();
         chk($sformatf("vec%0d_drain", i), 32'(bus.out_valid), 32'd0);
      end

      // Back-to-back inputs under backpressure: A, B, C.
      bus.data_in   = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 3'd0;
      tick();
      chk("bp_ready_one", 32'(bus.in_ready), 32'd1);
      bus.sel = 3'd1;
      tick();
      chk("bp_ready_two", 32'(bus.in_ready), 32'd0);
      bus.sel = 3'd2;
      tick();
      chk("bp_hold_data",  bus.data_out, 32'h0000_000A);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      chk("bp_out_b",      bus.data_out, 32'h0000_000B);
      chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
      tick();
      chk("bp_out_c", bus.data_out, 32'h0000_000C);
      bus.in_valid = 1'b0;
      tick();
      chk("bp_empty", 32'(bus.out_valid), 32'd0);

      // Flush while full with a concurrent input.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 3'd0;
      tick();
      tick();
      chk("fl_full", 32'(bus.in_ready), 32'd0);
      flush = 1'b1;
      tick();
      chk("fl_valid", 32'(bus.out_valid), 32'd0);
      chk("fl_ready", 32'(bus.in_ready),  32'd1);
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("fl_quiet%0d", i), 32'(bus.out_valid), 32'd0);
      end

      // Reset mid-operation beats flush and transfers.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 3'd1;
      tick();
      chk("mr_loaded", 32'(bus.out_valid), 32'd1);
      reset = 1'b1;
      flush = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      chk("mr_valid", 32'(bus.out_valid), 32'd0);
      chk("mr_ready", 32'(bus.in_ready),  32'd1);
      chk("mr_data",  bus.data_out,       32'd0);
      reset = 1'b0;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      tick();

      // Throughput with out_ready held high.
      begin
         int acc;
         int emit;
         acc  = 0;
         emit = 0;
         bus.out_ready = 1'b1;
         bus.in_valid  = 1'b1;
         for (int i = 0; i < 50; i++) begin
            bus.sel = 3'(i % 6);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            if (bus.out_valid && bus.out_ready) emit++;
            @(posedge clk);
            #1;
         end
         chk("tp_accepted", 32'(acc),  32'd50);
         chk("tp_emitted",  32'(emit), 32'd49);
         bus.in_valid = 1'b0;
         tick();
         tick();
      end

      // Random valid/ready against a queue scoreboard.
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         exp_t e;
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.sel       = 3'($urandom_range(0, 7));
         bus.data_in   = {$urandom, $urandom, $urandom};
         bus.imm16     = 16'($urandom);
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               n_total++;
               $display("FAIL sb_underflow: got unexpected %h expected none",
                        bus.data_out);
            end else begin
               e = q.pop_front();
               chk("sb_data", bus.data_out, e.data);
               chk("sb_err",  32'(bus.sel_err), 32'(e.err));
            end
         end
         if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.sel, bus.data_in, bus.imm16));
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         exp_t e;
         @(negedge clk);
         if (bus.out_valid && q.size() != 0) begin
            e = q.pop_front();
            chk("sb_drain", bus.data_out, e.data);
         end
         @(posedge clk);
         #1;
      end
      chk("sb_left", 32'(q.size()), 32'd0);
      chk("sb_idle", 32'(bus.out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_src_b_stage.md
ALU_SRC_B_STAGE -- requirements
Module: alu_src_b_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (WIDTH >= 18).
REQ-002 SHALL have parameter NUM_DATA, default 3, number of register-sourced data channels (1..8).
REQ-003 SHALL have parameter CONST_VAL, default 4, constant operand value (PC increment).
REQ-004 SHALL have localparam SEL_W = clog2(NUM_DATA+3), selector width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 flush  input  1  synchronous pipeline clear, lower priority than reset.
REQ-008 in_valid  input  1  upstream presents a transfer.
REQ-009 in_ready  output  1  stage can accept; taken from a register.
REQ-010 sel  input  SEL_W  operand mode for the presented transfer.
REQ-011 data_in  input  NUM_DATA*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 imm16  input  16  instruction immediate field.
REQ-013 out_valid  output  1  data_out holds a valid operand.
REQ-014 out_ready  input  1  downstream ALU accepts.
REQ-015 data_out  output  WIDTH  selected operand, registered.
REQ-016 sel_err  output  1  registered flag travelling with data_out; marks out-of-range sel.

Function
REQ-017 sel < NUM_DATA SHALL select channel sel of data_in.
REQ-018 sel = NUM_DATA SHALL select CONST_VAL zero-extended to WIDTH.
REQ-019 sel = NUM_DATA+1 SHALL select imm16 sign-extended to WIDTH.
REQ-020 sel = NUM_DATA+2 SHALL select imm16 sign-extended to WIDTH, then shifted left 2; upper bits discarded.
REQ-021 sel > NUM_DATA+2 SHALL produce operand 0 with sel_err = 1; sel_err = 0 for all other modes.
REQ-022 Transfer in occurs on cycle with in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-023 Latency SHALL be 1 cycle: operand accepted at edge N is on data_out with out_valid = 1 after edge N when stage was empty.
REQ-024 Storage SHALL be a main register plus one skid register; states EMPTY, ONE, TWO.
REQ-025 EMPTY: in -> ONE; no in -> EMPTY.
REQ-026 ONE: in & out -> ONE (main reloads); in only -> TWO (new operand to skid); out only -> EMPTY; neither -> ONE.
REQ-027 TWO: out -> ONE (skid moves to main); no out -> TWO; in_ready = 0 so no in.
REQ-028 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; sustained throughput 1 operand/cycle when out_ready = 1.
REQ-029 Order SHALL be preserved; no operand dropped or duplicated.
REQ-030 data_out and sel_err SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-031 flush SHALL force EMPTY on the next edge, discarding both entries and any same-cycle input transfer; in_ready = 1 after.
REQ-032 data_in/imm16/sel SHALL be ignored when in_valid = 0.

Reset
REQ-033 On reset: state EMPTY, out_valid = 0, in_ready = 1, data_out = 0, sel_err = 0, skid register = 0.
REQ-034 Reset mid-operation SHALL discard held operands; reset wins over flush and transfers in the same cycle.

Structure
REQ-035 Shared package SHALL hold the state encoding (EMPTY/ONE/TWO) and mode offsets (OFS_CONST = 0, OFS_IMM = 1, OFS_IMM_SHL2 = 2 relative to NUM_DATA).
REQ-036 Operand selection SHALL be a combinational sub-module alu_src_b_select (sel, data_in, imm16 -> operand, err); handshake/storage stays in top.

Verification
REQ-037 Defaults, reset, then sel=3 with in_valid=1, out_ready=1 -> next cycle data_out=0x00000004, out_valid=1, sel_err=0.
REQ-038 imm16=0xFFFC, sel=4 -> 0xFFFFFFFC; sel=5 -> 0xFFFFFFF0; imm16=0x7FFF, sel=5 -> 0x0001FFFC.
REQ-039 sel=6 and sel=7 -> data_out=0, sel_err=1.
REQ-040 out_ready=0, three back-to-back inputs ch0=0xA,ch1=0xB,ch2=0xC -> in_ready=0 after second; release -> outputs 0xA,0xB then third accepted, 0xC; order intact.
REQ-041 Stage in TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no operand later emitted.
REQ-042 Random valid/ready for 10k cycles vs scoreboard -> zero mismatches, 100% throughput when out_ready held 1.
